// File: rtl/window_scan_ctrl_if.sv
// Handshake bundle between the window scan sequencer, the pixel source,
// the 3x3 line memory and the downstream filter.
interface window_scan_ctrl_if #(
  parameter int ADDR_W = 15
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              out_ready;
  logic              mem_rst_n;
  logic              mem_wr;
  logic              mem_rd;
  logic [ADDR_W-1:0] win_base;
  logic              out_valid;
  logic [5:0]        out_row;
  logic [8:0]        out_col;
  logic              busy;
  logic              frame_done;

  modport master (
    input  start, in_valid, out_ready,
    output in_ready, mem_rst_n, mem_wr, mem_rd, win_base,
           out_valid, out_row, out_col, busy, frame_done
  );

  modport slave (
    output start, in_valid, out_ready,
    input  in_ready, mem_rst_n, mem_wr, mem_rd, win_base,
           out_valid, out_row, out_col, busy, frame_done
  );
endinterface

// File: rtl/window_scan_ctrl.sv
// Sequencer for the 3x3 window line memory: clear, load one padded frame,
// then read one window per output pixel in raster order under backpressure.
module window_scan_ctrl #(
  parameter int IMG_W  = 256,
  parameter int OUT_H  = 32,
  parameter int ADDR_W = 15
) (
  input  logic                clk,
  input  logic                rst,
  window_scan_ctrl_if.master  bus
);

  localparam int PAD_W = IMG_W + 2;
  localparam int PAD_H = OUT_H + 2;

  localparam logic [ADDR_W-1:0] LD_LAST  = ADDR_W'(PAD_W * PAD_H - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  // Moving from the last column to the next row skips the two pad words.
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(PAD_W - IMG_W + 1);
  localparam logic [8:0]        COL_LAST = 9'(IMG_W - 1);
  localparam logic [5:0]        ROW_LAST = 6'(OUT_H - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SCAN  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state_r;
  logic [2:0]        next_s;
  logic [ADDR_W-1:0] ld_cnt_r;
  logic [8:0]        col_r;
  logic [5:0]        row_r;
  logic [ADDR_W-1:0] base_r;
  logic              out_valid_r;
  logic [5:0]        out_row_r;
  logic [8:0]        out_col_r;
  logic              busy_r;
  logic              frame_done_r;
  logic              wr_s;
  logic              rd_s;
  logic              last_win_s;

  // Strobes follow the handshake inputs directly and are killed while rst is high.
  assign wr_s       = !rst && (state_r == S_LOAD) && bus.in_valid;
  assign rd_s       = !rst && (state_r == S_SCAN) && bus.out_ready;
  assign last_win_s = (row_r == ROW_LAST) && (col_r == COL_LAST);

  assign bus.in_ready   = !rst && (state_r == S_LOAD);
  assign bus.mem_wr     = wr_s;
  assign bus.mem_rd     = rd_s;
  assign bus.mem_rst_n  = !rst && (state_r != S_CLR);
  assign bus.win_base   = base_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_row    = out_row_r;
  assign bus.out_col    = out_col_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;

  // Next-state decode for the frame sequencer.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) next_s = S_CLR;
        else           next_s = S_IDLE;
      end
      S_CLR:  next_s = S_LOAD;
      S_LOAD: begin
        if (wr_s && (ld_cnt_r == LD_LAST)) next_s = S_SCAN;
        else                               next_s = S_LOAD;
      end
      S_SCAN: begin
        if (rd_s && last_win_s) next_s = S_DRAIN;
        else                    next_s = S_SCAN;
      end
      S_DRAIN: next_s = S_DONE;
      S_DONE:  next_s = S_IDLE;
      default: next_s = S_IDLE;
    endcase
  end

  // State register plus registered status flags and read-latency tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      out_valid_r  <= 1'b0;
      out_row_r    <= 6'd0;
      out_col_r    <= 9'd0;
    end else begin
      state_r      <= next_s;
      busy_r       <= (next_s != S_IDLE);
      frame_done_r <= (next_s == S_DONE);
      out_valid_r  <= rd_s;
      out_row_r    <= row_r;
      out_col_r    <= col_r;
    end
  end

  // Load counter and raster position; win_base tracks row*PAD_W+col incrementally.
  always_ff @(posedge clk) begin
    if (rst || (state_r == S_IDLE)) begin
      ld_cnt_r <= '0;
      col_r    <= 9'd0;
      row_r    <= 6'd0;
      base_r   <= '0;
    end else begin
      if (wr_s) begin
        if (ld_cnt_r == LD_LAST) ld_cnt_r <= '0;
        else                     ld_cnt_r <= ld_cnt_r + ADDR_ONE;
      end
      if (rd_s) begin
        if (last_win_s) begin
          col_r  <= 9'd0;
          row_r  <= 6'd0;
          base_r <= '0;
        end else if (col_r == COL_LAST) begin
          col_r  <= 9'd0;
          row_r  <= row_r + 6'd1;
          base_r <= base_r + ROW_STEP;
        end else begin
          col_r  <= col_r + 9'd1;
          base_r <= base_r + ADDR_ONE;
        end
      end
    end
  end

endmodule
